// File: rtl/grid_cfg_pkg.sv
// grid_cfg_pkg: shared types and geometry constants for the grid overlay configuration
package grid_cfg_pkg;
   typedef enum logic [1:0] {IDLE, WAIT_VS, BLANK} state_t;
   localparam logic MODE_TIME = 1'b0;
   localparam logic MODE_FFT  = 1'b1;
   localparam int AMP_W = 2;
   localparam logic [11:0] T_Y_TOP = 12'd9;
   localparam logic [11:0] T_Y_BOT = 12'd1075;
   localparam logic [11:0] F_Y_TOP = 12'd210;
   localparam logic [11:0] F_Y_BOT = 12'd980;
   localparam logic [11:0] X_LEFT  = 12'd442;
   localparam logic [11:0] X_RIGHT = 12'd1521;
   localparam logic [6:0]  T_PITCH = 7'd60;
   localparam logic [6:0]  F_PITCH = 7'd55;
endpackage

// File: rtl/frame_edge_det.sv
// frame_edge_det: single-cycle pulse on the leading edge of an active vsync
module frame_edge_det #(
   parameter logic POL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic vs,
   output logic vs_start
);
   logic vs_q;
   // delayed vsync, reset to the active level so a vsync already high at release is not an edge
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) vs_q <= POL;
      else        vs_q <= vs;
   assign vs_start = (vs == POL) && (vs_q != POL);
endmodule

// File: rtl/grid_cfg_ctrl.sv
// grid_cfg_ctrl: holds mode requests until a frame edge, blanks, then applies geometry atomically
module grid_cfg_ctrl
   import grid_cfg_pkg::*;
#(
   parameter int unsigned BLANK_FRAMES = 1,
   parameter logic        VS_POL       = 1'b1
) (
   input  logic             pclk,
   input  logic             rst_n,
   input  logic             i_vs,
   input  logic             req_valid,
   input  logic             req_fft,
   input  logic [AMP_W-1:0] req_amp,
   output logic             req_ready,
   output logic             cfg_fft,
   output logic [AMP_W-1:0] cfg_amp,
   output logic [11:0]      cfg_y_top,
   output logic [11:0]      cfg_y_bot,
   output logic [11:0]      cfg_x_left,
   output logic [11:0]      cfg_x_right,
   output logic [6:0]       cfg_pitch,
   output logic             cfg_blank,
   output logic             cfg_update,
   output logic             busy
);
   localparam logic [3:0] NB = 4'(BLANK_FRAMES);
   state_t state, nxt;
   logic vs_start, pend_fft, ld, apply, blank_n;
   logic [AMP_W-1:0] pend_amp;
   logic [3:0] cnt, cnt_n;

   frame_edge_det #(.POL(VS_POL)) u_edge (
      .clk(pclk), .rst_n(rst_n), .vs(i_vs), .vs_start(vs_start)
   );

   // next state, pending capture, blank frame counting and apply decision
   always_comb begin
      nxt = state;
      ld = 1'b0;
      apply = 1'b0;
      blank_n = cfg_blank;
      cnt_n = cnt;
      case (state)
         IDLE: if (req_valid && req_ready) begin
            ld = 1'b1;
            nxt = ({req_fft, req_amp} != {cfg_fft, cfg_amp}) ? WAIT_VS : IDLE;
         end
         WAIT_VS: if (vs_start) begin
            if (NB == 4'd0) begin
               apply = 1'b1;
               nxt = IDLE;
            end else begin
               blank_n = 1'b1;
               cnt_n = NB;
               nxt = BLANK;
            end
         end
         BLANK: if (vs_start) begin
            if (cnt == 4'd1) begin
               apply = 1'b1;
               blank_n = 1'b0;
               nxt = IDLE;
            end else cnt_n = cnt - 4'd1;
         end
         default: nxt = IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge pclk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt;

   // pending request, blank counter and all registered outputs
   always_ff @(posedge pclk or negedge rst_n)
      if (!rst_n) begin
         pend_fft <= MODE_TIME;
         pend_amp <= '0;
         cnt <= 4'd0;
         cfg_fft <= MODE_TIME;
         cfg_amp <= '0;
         cfg_y_top <= T_Y_TOP;
         cfg_y_bot <= T_Y_BOT;
         cfg_x_left <= X_LEFT;
         cfg_x_right <= X_RIGHT;
         cfg_pitch <= T_PITCH;
         cfg_blank <= 1'b0;
         cfg_update <= 1'b0;
         busy <= 1'b0;
         req_ready <= 1'b1;
      end else begin
         if (ld) {pend_fft, pend_amp} <= {req_fft, req_amp};
         cnt <= cnt_n;
         cfg_blank <= blank_n;
         cfg_update <= apply;
         busy <= nxt != IDLE;
         req_ready <= nxt == IDLE;
         if (apply) begin
            cfg_fft <= pend_fft;
            cfg_amp <= pend_amp;
            cfg_y_top <= (pend_fft == MODE_FFT) ? F_Y_TOP : T_Y_TOP;
            cfg_y_bot <= (pend_fft == MODE_FFT) ? F_Y_BOT : T_Y_BOT;
            cfg_x_left <= X_LEFT;
            cfg_x_right <= X_RIGHT;
            cfg_pitch <= (pend_fft == MODE_FFT) ? F_PITCH : T_PITCH;
         end
      end
endmodule

// File: tb/tb_grid_cfg_ctrl.sv
// tb_grid_cfg_ctrl: directed scoreboard bench for grid_cfg_ctrl with BLANK_FRAMES 1 and 0
module tb_grid_cfg_ctrl;
   logic pclk = 1'b0;
   logic rst_n, i_vs, valid1, valid0, req_fft;
   logic [1:0] req_amp;
   logic a_ready, a_fft, a_blank, a_update, a_busy;
   logic z_ready, z_fft, z_blank, z_update, z_busy;
   logic [1:0] a_amp, z_amp;
   logic [11:0] a_yt, a_yb, a_xl, a_xr, z_yt, z_yb, z_xl, z_xr;
   logic [6:0] a_pitch, z_pitch;
   logic [57:0] q1[$];
   logic [57:0] q0[$];
   int passed = 0, total = 0, upd1 = 0, upd0 = 0;
   logic blank0_seen = 1'b0;

   wire [57:0] obs1 = {a_fft, a_amp, a_yt, a_yb, a_xl, a_xr, a_pitch};
   wire [57:0] obs0 = {z_fft, z_amp, z_yt, z_yb, z_xl, z_xr, z_pitch};
   wire [3:0]  st1  = {a_blank, a_update, a_busy, a_ready};
   wire [3:0]  st0  = {z_blank, z_update, z_busy, z_ready};

   always #5 pclk = ~pclk;

   grid_cfg_ctrl #(.BLANK_FRAMES(1), .VS_POL(1'b1)) u1 (
      .pclk(pclk), .rst_n(rst_n), .i_vs(i_vs), .req_valid(valid1), .req_fft(req_fft),
      .req_amp(req_amp), .req_ready(a_ready), .cfg_fft(a_fft), .cfg_amp(a_amp),
      .cfg_y_top(a_yt), .cfg_y_bot(a_yb), .cfg_x_left(a_xl), .cfg_x_right(a_xr),
      .cfg_pitch(a_pitch), .cfg_blank(a_blank), .cfg_update(a_update), .busy(a_busy)
   );

   grid_cfg_ctrl #(.BLANK_FRAMES(0), .VS_POL(1'b1)) u0 (
      .pclk(pclk), .rst_n(rst_n), .i_vs(i_vs), .req_valid(valid0), .req_fft(req_fft),
      .req_amp(req_amp), .req_ready(z_ready), .cfg_fft(z_fft), .cfg_amp(z_amp),
      .cfg_y_top(z_yt), .cfg_y_bot(z_yb), .cfg_x_left(z_xl), .cfg_x_right(z_xr),
      .cfg_pitch(z_pitch), .cfg_blank(z_blank), .cfg_update(z_update), .busy(z_busy)
   );

   function automatic logic [57:0] exp_cfg(input logic f, input logic [1:0] a);
      return f ? {f, a, 12'd210, 12'd980, 12'd442, 12'd1521, 7'd55}
               : {f, a, 12'd9, 12'd1075, 12'd442, 12'd1521, 7'd60};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic vs_rise();
      i_vs = 1'b1;
      tick();
   endtask

   task automatic vs_fall();
      i_vs = 1'b0;
      repeat (4) tick();
   endtask

   // scoreboard: every cfg_update pops the oldest expected configuration
   always @(negedge pclk) begin
      if (rst_n && a_update) begin
         upd1++;
         chk("u1 update expected", 64'(q1.size() != 0), 64'd1);
         if (q1.size() != 0) chk("u1 update cfg", obs1, q1.pop_front());
      end
      if (rst_n && z_update) begin
         upd0++;
         chk("u0 update expected", 64'(q0.size() != 0), 64'd1);
         if (q0.size() != 0) chk("u0 update cfg", obs0, q0.pop_front());
      end
      if (z_blank) blank0_seen = 1'b1;
   end

   initial begin
      rst_n = 1'b0; i_vs = 1'b1; valid1 = 1'b0; valid0 = 1'b0; req_fft = 1'b0; req_amp = 2'd0;
      repeat (3) tick();
      chk("reset cfg", obs1, exp_cfg(1'b0, 2'd0));
      chk("reset flags", st1, 4'b0001);
      chk("reset cfg b0", obs0, exp_cfg(1'b0, 2'd0));
      rst_n = 1'b1;
      repeat (3) tick();
      chk("release flags", st1, 4'b0001);
      chk("release cfg", obs1, exp_cfg(1'b0, 2'd0));
      i_vs = 1'b0;
      repeat (4) tick();
      req_fft = 1'b1; req_amp = 2'd2; valid1 = 1'b1;
      tick();
      valid1 = 1'b0;
      q1.push_back(exp_cfg(1'b1, 2'd2));
      chk("accept flags", st1, 4'b0010);
      vs_rise();
      chk("blank after vs1", st1, 4'b1010);
      vs_fall();
      chk("blank held", st1, 4'b1010);
      chk("cfg unchanged while blank", obs1, exp_cfg(1'b0, 2'd0));
      vs_rise();
      chk("apply flags", st1, 4'b0101);
      chk("apply cfg", obs1, exp_cfg(1'b1, 2'd2));
      tick();
      chk("update single cycle", st1, 4'b0001);
      vs_fall();
      req_fft = 1'b1; req_amp = 2'd2; valid1 = 1'b1;
      tick();
      valid1 = 1'b0;
      chk("equal req no busy", st1, 4'b0001);
      vs_rise();
      chk("equal req idle on vs", st1, 4'b0001);
      vs_fall();
      vs_rise();
      vs_fall();
      chk("equal req no update", upd1, 1);
      req_fft = 1'b0; req_amp = 2'd1; valid1 = 1'b1; i_vs = 1'b1;
      tick();
      q1.push_back(exp_cfg(1'b0, 2'd1));
      req_fft = 1'b1; req_amp = 2'd3;
      chk("accept with vs flags", st1, 4'b0010);
      repeat (3) tick();
      chk("vs at accept ignored", st1, 4'b0010);
      vs_fall();
      vs_rise();
      chk("blank after next vs", st1, 4'b1010);
      vs_fall();
      chk("ready low in blank", st1, 4'b1010);
      vs_rise();
      chk("apply2 flags", st1, 4'b0101);
      chk("apply2 cfg", obs1, exp_cfg(1'b0, 2'd1));
      q1.push_back(exp_cfg(1'b1, 2'd3));
      tick();
      valid1 = 1'b0;
      chk("held req accepted", st1, 4'b0010);
      vs_fall();
      vs_rise();
      chk("blank3", st1, 4'b1010);
      vs_fall();
      vs_rise();
      chk("apply3 flags", st1, 4'b0101);
      chk("apply3 cfg", obs1, exp_cfg(1'b1, 2'd3));
      vs_fall();
      chk("u1 update count", upd1, 3);
      req_fft = 1'b1; req_amp = 2'd1; valid0 = 1'b1;
      tick();
      valid0 = 1'b0;
      q0.push_back(exp_cfg(1'b1, 2'd1));
      chk("b0 busy", st0, 4'b0010);
      vs_rise();
      chk("b0 apply flags", st0, 4'b0101);
      chk("b0 apply cfg", obs0, exp_cfg(1'b1, 2'd1));
      vs_fall();
      chk("b0 idle", st0, 4'b0001);
      req_fft = 1'b0; req_amp = 2'd3; valid1 = 1'b1;
      tick();
      valid1 = 1'b0;
      vs_rise();
      chk("pre-reset blank", st1, 4'b1010);
      vs_fall();
      #2 rst_n = 1'b0;
      #1;
      chk("async reset flags", st1, 4'b0001);
      chk("async reset cfg", obs1, exp_cfg(1'b0, 2'd0));
      tick();
      rst_n = 1'b1;
      tick();
      vs_rise();
      vs_fall();
      vs_rise();
      vs_fall();
      chk("no update after reset", upd1, 3);
      chk("post-reset flags", st1, 4'b0001);
      chk("post-reset cfg", obs1, exp_cfg(1'b0, 2'd0));
      chk("u1 queue drained", q1.size(), 0);
      chk("u0 queue drained", q0.size(), 0);
      chk("u0 update count", upd0, 1);
      chk("b0 blank never", blank0_seen, 1'b0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/grid_cfg_ctrl.md
# grid_cfg_ctrl

Frame-synchronous configuration controller for the HDMI grid overlay. It accepts display-mode requests (time/FFT view, amplitude range) through a valid/ready handshake and holds each one until a frame boundary. It then blanks the overlay for a programmable number of frames and applies the new geometry atomically at a vsync edge. It sits between the user-control logic and `grid_display`, driving that block's mode and geometry inputs so that a mode change never tears a frame.

## Interface
- `BLANK_FRAMES`, default 1: whole frames blanked before a new config is applied; range 0–15.
- `VS_POL`, default 1: active level of `i_vs`; 1 means active-high.
- `pclk`  in  1  pixel clock; the only clock.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `i_vs`  in  1  vsync from the timing chain.
- `req_valid`  in  1  a mode request is present.
- `req_fft`  in  1  requested view: 0 = time, 1 = FFT.
- `req_amp`  in  2  requested amplitude range code.
- `req_ready`  out  1  controller can accept a request.
- `cfg_fft`  out  1  applied view.
- `cfg_amp`  out  2  applied amplitude code.
- `cfg_y_top`, `cfg_y_bot`, `cfg_x_left`, `cfg_x_right`  out  12 each  grid region bounds, inclusive.
- `cfg_pitch`  out  7  fine-grid pitch in pixels.
- `cfg_blank`  out  1  overlay must output black inside the region.
- `cfg_update`  out  1  one-cycle pulse in the cycle the cfg registers change.
- `busy`  out  1  a request is pending.

## Operation
- Frame start: `vs_start = (i_vs == VS_POL) & (vs_q != VS_POL)`. `vs_q` is `i_vs` registered once.
- Geometry is decoded from the mode:
  - Time mode: y 9..1075, x 442..1521, pitch 60.
  - FFT mode: y 210..980, x 442..1521, pitch 55.
- `cfg_amp` passes through unchanged at the point of apply.
- The FSM has three states: IDLE, WAIT_VS, BLANK.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid & req_ready`, capture `{req_fft, req_amp}` into pending registers.
  - If the pending value equals `{cfg_fft, cfg_amp}`, discard it: stay in IDLE, no pulse.
  - Otherwise go to WAIT_VS.
- WAIT_VS:
  - On `vs_start`, if `BLANK_FRAMES == 0`, apply immediately and return to IDLE.
  - Otherwise set `cfg_blank` = 1, load `cnt = BLANK_FRAMES`, and go to BLANK.
- BLANK:
  - On `vs_start` with `cnt == 1`, apply, clear `cfg_blank`, and return to IDLE.
  - On `vs_start` with `cnt > 1`, decrement `cnt`.
- Apply means that, in a single cycle, all cfg outputs load from the pending value and `cfg_update` = 1.
- `busy` = 1 in WAIT_VS and BLANK. `req_ready` = 0 in those states, so no request is lost or overwritten.
- Boundary conditions:
  - A `vs_start` in the same cycle as request acceptance is not counted; waiting starts from the next frame edge.
  - `vs_start` has no effect in IDLE.
  - `i_vs` held constant means the controller stays pending indefinitely, with no timeout.
  - Asserting `rst_n` mid-operation aborts the pending request and returns all outputs to reset values.

## Timing
- Reset values:
  - FSM = IDLE, `vs_q = VS_POL` so a vsync already active at reset release is not seen as an edge.
  - `cfg_fft` = 0, `cfg_amp` = 0.
  - Geometry = time-mode values (9, 1075, 442, 1521, 60).
  - `cfg_blank` = 0, `cfg_update` = 0, `busy` = 0, `req_ready` = 1.
- All outputs are registered; none is combinational from inputs.
- Request accepted at clock edge N: `busy` = 1 and `req_ready` = 0 from N+1.
- First `vs_start` after acceptance, with `BLANK_FRAMES` = B ≥ 1:
  - `cfg_blank` rises on the edge after that sample.
  - Apply occurs on the B-th subsequent `vs_start`.
  - Exactly B full frames are blanked.
- `req_ready` returns to 1 in the cycle after apply, so the next request can be accepted one cycle after `cfg_update`.
- Pending-registers-to-cfg-output latency: 1 cycle from the `vs_start` sample.

## Structure
- Shared package `grid_cfg_pkg` holds:
  - FSM state enum.
  - Mode constants `MODE_TIME`/`MODE_FFT`.
  - Geometry constants: `T_Y_TOP`=9, `T_Y_BOT`=1075, `F_Y_TOP`=210, `F_Y_BOT`=980, `X_LEFT`=442, `X_RIGHT`=1521, `T_PITCH`=60, `F_PITCH`=55.
  - Amplitude code width.
- One sub-module, `frame_edge_det`: parameter `POL`; registers `i_vs` and emits the `vs_start` pulse with reset-safe initial state. It is reused by other frame-synchronous blocks.

## Test plan
- Reset with `i_vs` held active, then release → no `vs_start`; outputs at time-mode defaults (9/1075/442/1521/60); `req_ready` = 1.
- B=1: request fft=1, amp=2 → blank rises after the 1st vsync edge; after the 2nd, `cfg_update` pulses once and cfg = 210/980/442/1521/55, amp 2; blank falls.
- Request equal to the current config → accepted, `busy` never rises, no `cfg_update`.
- `req_valid` held during BLANK with a different value → `req_ready` = 0 until one cycle after apply, then accepted; two updates total.
- B=0 → `cfg_update` on the first vsync edge after acceptance; `cfg_blank` never asserts.
- Deassert `rst_n` while in BLANK → outputs return to reset values immediately; no `cfg_update` afterwards.
